// File: rtl/alu_share_arbiter_if.sv
// Bundle of request, response and ALU-side signals for alu_share_arbiter.
// The slave modport is the arbiter's view; the master modport is the view of
// the environment (both requesters plus the shared combinational ALU).
interface alu_share_arbiter_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OPW   = 4
);
  // requester 0 request channel
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [OPW-1:0]   req0_op;
  // requester 1 request channel
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [OPW-1:0]   req1_op;
  // response channels (data/zero shared by both)
  logic             resp0_valid;
  logic             resp0_ready;
  logic             resp1_valid;
  logic             resp1_ready;
  logic [WIDTH-1:0] resp_data;
  logic             resp_zero;
  // shared ALU
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [OPW-1:0]   alu_opcode;
  logic [WIDTH-1:0] alu_out;
  logic             alu_zero;
  // status
  logic             busy;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req1_ready,
    output resp0_valid, resp1_valid, resp_data, resp_zero,
    input  resp0_ready, resp1_ready,
    output alu_a, alu_b, alu_opcode,
    input  alu_out, alu_zero,
    output busy
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req1_ready,
    input  resp0_valid, resp1_valid, resp_data, resp_zero,
    output resp0_ready, resp1_ready,
    input  alu_a, alu_b, alu_opcode,
    output alu_out, alu_zero,
    input  busy
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters.
// One operation in flight: IDLE (arbitrate/accept) -> EXEC (ALU evaluates
// registered operands) -> RESP (hold result until the owner consumes it).
module alu_share_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OPW   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_share_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             owner_q, owner_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [OPW-1:0]   alu_op_q, alu_op_d;
  logic [WIDTH-1:0] resp_data_q, resp_data_d;
  logic             resp_zero_q, resp_zero_d;

  logic             any_valid;
  logic             grant;
  logic             req0_ready;
  logic             req1_ready;
  logic             resp0_valid;
  logic             resp1_valid;
  logic             resp_fire;

  // Round-robin grant: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    any_valid = bus.req0_valid | bus.req1_valid;
    grant     = 1'b0;
    if (bus.req0_valid & bus.req1_valid) begin
      grant = ~last_grant_q;
    end else if (bus.req1_valid) begin
      grant = 1'b1;
    end
  end

  // Next-state, operand/result capture and handshake outputs.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    resp_data_d  = resp_data_q;
    resp_zero_d  = resp_zero_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    resp0_valid  = 1'b0;
    resp1_valid  = 1'b0;
    resp_fire    = 1'b0;

    case (state_q)
      IDLE: begin
        req0_ready = bus.req0_valid & ~grant;
        req1_ready = bus.req1_valid & grant;
        if (any_valid) begin
          state_d      = EXEC;
          owner_d      = grant;
          last_grant_d = grant;
          if (grant) begin
            alu_a_d  = bus.req1_a;
            alu_b_d  = bus.req1_b;
            alu_op_d = bus.req1_op;
          end else begin
            alu_a_d  = bus.req0_a;
            alu_b_d  = bus.req0_b;
            alu_op_d = bus.req0_op;
          end
        end
      end

      EXEC: begin
        resp_data_d = bus.alu_out;
        resp_zero_d = bus.alu_zero;
        state_d     = RESP;
      end

      RESP: begin
        resp0_valid = ~owner_q;
        resp1_valid = owner_q;
        resp_fire   = owner_q ? bus.resp1_ready : bus.resp0_ready;
        if (resp_fire) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset also discards any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      resp_data_q  <= '0;
      resp_zero_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      resp_data_q  <= resp_data_d;
      resp_zero_q  <= resp_zero_d;
    end
  end

  assign bus.req0_ready  = req0_ready;
  assign bus.req1_ready  = req1_ready;
  assign bus.resp0_valid = resp0_valid;
  assign bus.resp1_valid = resp1_valid;
  assign bus.resp_data   = resp_data_q;
  assign bus.resp_zero   = resp_zero_q;
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.alu_opcode  = alu_op_q;
  assign bus.busy        = (state_q != IDLE);

endmodule
